// File: rtl/sram_controller.sv
// Word load/store engine for the MEM stage against a 16-bit async SRAM.
// Each 32-bit word is moved as two half-word cycles; pause holds the pipeline.
module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        pause,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        WAIT,
        DONE
    } state_e;

    state_e        state_q;
    logic          cmd_wr_q;
    logic [16:0]   word_q;
    logic [16:0]   word_d;
    logic          half_q;
    logic [31:0]   wdata_q;
    logic [15:0]   rd_lo_q;
    logic [15:0]   rd_hi_q;
    logic [31:0]   read_data_q;
    logic [CW-1:0] cnt_q;
    logic          active;

    // Offset from the window base; addresses below it wrap within 2^17 words.
    assign word_d = 17'((address - 32'(BASE_ADDR)) >> 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_wr_q    <= 1'b0;
            word_q      <= '0;
            half_q      <= 1'b0;
            wdata_q     <= '0;
            rd_lo_q     <= '0;
            rd_hi_q     <= '0;
            read_data_q <= '0;
            cnt_q       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rd_en || wr_en) begin
                        cmd_wr_q <= wr_en;
                        word_q   <= word_d;
                        wdata_q  <= write_data;
                        half_q   <= 1'b0;
                        state_q  <= LO;
                    end
                end
                LO: begin
                    if (!cmd_wr_q) rd_lo_q <= SRAM_DQ;
                    half_q  <= 1'b1;
                    state_q <= HI;
                end
                HI: begin
                    if (!cmd_wr_q) rd_hi_q <= SRAM_DQ;
                    cnt_q   <= CW'(WAIT_CYCLES - 1);
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == '0) state_q <= DONE;
                    else cnt_q <= cnt_q - CW'(1);
                end
                DONE: begin
                    if (!cmd_wr_q) read_data_q <= {rd_hi_q, rd_lo_q};
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign active    = (state_q == LO) || (state_q == HI);
    assign SRAM_ADDR = {word_q, half_q};
    assign SRAM_WE_N = !(active && cmd_wr_q);
    assign SRAM_OE_N = !(active && !cmd_wr_q);
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_DQ   = (active && cmd_wr_q) ?
                       (half_q ? wdata_q[31:16] : wdata_q[15:0]) : 16'hzzzz;

    // The MEM register captures the load result at the DONE edge, so bypass it.
    assign read_data = (state_q == DONE && !cmd_wr_q) ?
                       {rd_hi_q, rd_lo_q} : read_data_q;
    assign pause     = (state_q == IDLE) ? (rd_en || wr_en) :
                       (state_q != DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural 256Kx16 async SRAM.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        pause;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;

    logic [15:0] mem [0:262143];
    logic        pl_en = 1'b0;
    logic [17:0] pl_addr = '0;
    logic [15:0] pl_data = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_controller dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .pause      (pause),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WE_N  (we_n),
        .SRAM_OE_N  (oe_n),
        .SRAM_CE_N  (ce_n),
        .SRAM_UB_N  (ub_n),
        .SRAM_LB_N  (lb_n)
    );

    // Async SRAM: drives the bus on read, stores on a low write strobe.
    assign sram_dq = (!oe_n && we_n && !ce_n) ? mem[sram_addr] : 16'hzzzz;

    always @(negedge clk) begin
        if (!we_n && !ce_n) mem[sram_addr] <= sram_dq;
        if (pl_en) mem[pl_addr] <= pl_data;
    end

    task automatic run_access(input logic w, input logic r,
                              input logic [31:0] a, input logic [31:0] d,
                              output int cyc, output int phigh,
                              output logic [31:0] rdat,
                              output logic saw_oe);
        wr_en = w;
        rd_en = r;
        address = a;
        write_data = d;
        cyc = 0;
        phigh = 0;
        saw_oe = 1'b0;
        rdat = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (!oe_n) saw_oe = 1'b1;
            if (pause) phigh++;
            else begin
                rdat = read_data;
                break;
            end
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (pause !== 1'b0) begin
            failures++;
            $display("FAIL rst_pause: got %b expected 0", pause);
        end
        checks++;
        if (read_data !== 32'h0) begin
            failures++;
            $display("FAIL rst_read_data: got %h expected 0", read_data);
        end
        checks++;
        if ({we_n, oe_n} !== 2'b11) begin
            failures++;
            $display("FAIL rst_strobes: got %b expected 11", {we_n, oe_n});
        end
        checks++;
        if ({ce_n, ub_n, lb_n} !== 3'b000) begin
            failures++;
            $display("FAIL rst_ties: got %b expected 000", {ce_n, ub_n, lb_n});
        end
        checks++;
        if (sram_addr !== 18'h0) begin
            failures++;
            $display("FAIL rst_addr: got %h expected 0", sram_addr);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_write;
        int cyc, ph;
        logic [31:0] rd;
        logic oe;
        run_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, cyc, ph, rd, oe);
        checks++;
        if (cyc != 6) begin
            failures++;
            $display("FAIL wr_cycles: got %0d expected 6", cyc);
        end
        checks++;
        if (ph != 5) begin
            failures++;
            $display("FAIL wr_pause_len: got %0d expected 5", ph);
        end
        checks++;
        if (mem[0] !== 16'hBEEF || mem[1] !== 16'hDEAD) begin
            failures++;
            $display("FAIL wr_mem: got %h_%h expected DEAD_BEEF", mem[1], mem[0]);
        end
        checks++;
        if (oe) begin
            failures++;
            $display("FAIL wr_oe: got OE_N low expected high");
        end
        @(negedge clk);
        checks++;
        if (pause !== 1'b0) begin
            failures++;
            $display("FAIL wr_idle_pause: got %b expected 0", pause);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_read;
        int cyc, ph;
        logic [31:0] rd;
        logic oe;
        run_access(1'b0, 1'b1, 32'd1024, 32'h0, cyc, ph, rd, oe);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rd_done_data: got %h expected deadbeef", rd);
        end
        checks++;
        if (cyc != 6 || ph != 5) begin
            failures++;
            $display("FAIL rd_timing: got %0d/%0d expected 6/5", cyc, ph);
        end
        @(negedge clk);
        checks++;
        if (read_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rd_held: got %h expected deadbeef", read_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        int c1, c2, p1, p2;
        logic [31:0] r1, r2;
        logic o1, o2;
        run_access(1'b1, 1'b0, 32'd1028, 32'h12345678, c1, p1, r1, o1);
        run_access(1'b0, 1'b1, 32'd1028, 32'h0, c2, p2, r2, o2);
        checks++;
        if (c1 + c2 != 12) begin
            failures++;
            $display("FAIL b2b_cycles: got %0d expected 12", c1 + c2);
        end
        checks++;
        if (mem[2] !== 16'h5678 || mem[3] !== 16'h1234) begin
            failures++;
            $display("FAIL b2b_mem: got %h_%h expected 1234_5678", mem[3], mem[2]);
        end
        checks++;
        if (r2 !== 32'h12345678) begin
            failures++;
            $display("FAIL b2b_read: got %h expected 12345678", r2);
        end
    endtask

    task automatic test_both_enables;
        int cyc, ph;
        logic [31:0] rd;
        logic oe;
        run_access(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, cyc, ph, rd, oe);
        checks++;
        if (mem[4] !== 16'h5A5A || mem[5] !== 16'hA5A5) begin
            failures++;
            $display("FAIL both_mem: got %h_%h expected a5a5_5a5a", mem[5], mem[4]);
        end
        checks++;
        if (oe) begin
            failures++;
            $display("FAIL both_oe: got OE_N low expected high");
        end
        checks++;
        if (rd !== 32'h12345678) begin
            failures++;
            $display("FAIL both_rd_hold: got %h expected 12345678", rd);
        end
    endtask

    task automatic test_reset_mid;
        int cyc, ph;
        logic [31:0] rd;
        logic oe;
        wr_en = 1'b1;
        address = 32'd1044;
        write_data = 32'h0BAD0BAD;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        checks++;
        if (pause !== 1'b0) begin
            failures++;
            $display("FAIL rmid_pause: got %b expected 0", pause);
        end
        checks++;
        if ({we_n, oe_n} !== 2'b11) begin
            failures++;
            $display("FAIL rmid_strobes: got %b expected 11", {we_n, oe_n});
        end
        checks++;
        if (sram_addr !== 18'h0 || read_data !== 32'h0) begin
            failures++;
            $display("FAIL rmid_cleared: got %h/%h expected 0/0", sram_addr, read_data);
        end
        @(posedge clk);
        #1;
        run_access(1'b0, 1'b1, 32'd1024, 32'h0, cyc, ph, rd, oe);
        checks++;
        if (rd !== 32'hDEADBEEF || cyc != 6) begin
            failures++;
            $display("FAIL rmid_read: got %h/%0d expected deadbeef/6", rd, cyc);
        end
    endtask

    task automatic test_preload_hold;
        int cyc, ph;
        logic [31:0] rd;
        logic oe;
        pl_en = 1'b1;
        pl_addr = 18'd6;
        pl_data = 16'hCAFE;
        @(posedge clk);
        #1;
        pl_addr = 18'd7;
        pl_data = 16'hBABE;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
        run_access(1'b0, 1'b1, 32'd1036, 32'h0, cyc, ph, rd, oe);
        checks++;
        if (rd !== 32'hBABECAFE) begin
            failures++;
            $display("FAIL pre_read: got %h expected babecafe", rd);
        end
        run_access(1'b1, 1'b0, 32'd1040, 32'h55556666, cyc, ph, rd, oe);
        checks++;
        if (rd !== 32'hBABECAFE) begin
            failures++;
            $display("FAIL pre_hold_done: got %h expected babecafe", rd);
        end
        @(negedge clk);
        checks++;
        if (read_data !== 32'hBABECAFE) begin
            failures++;
            $display("FAIL pre_hold_after: got %h expected babecafe", read_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap;
        int cyc, ph;
        logic [31:0] rd;
        logic oe;
        run_access(1'b1, 1'b0, 32'd1020, 32'h11112222, cyc, ph, rd, oe);
        checks++;
        if (mem[18'h3FFFE] !== 16'h2222 || mem[18'h3FFFF] !== 16'h1111) begin
            failures++;
            $display("FAIL wrap_mem: got %h_%h expected 1111_2222",
                     mem[18'h3FFFF], mem[18'h3FFFE]);
        end
        run_access(1'b0, 1'b1, 32'd1020, 32'h0, cyc, ph, rd, oe);
        checks++;
        if (rd !== 32'h11112222) begin
            failures++;
            $display("FAIL wrap_read: got %h expected 11112222", rd);
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_back_to_back;
        test_both_enables;
        test_reset_mid;
        test_preload_hold;
        test_wrap;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
